// File: rtl/ascon_aead128_pkg.sv
// ascon_aead128_pkg: shared Ascon state type, round constants, permutation FSM states and helpers.
package ascon_aead128_pkg;

    typedef struct packed {
        logic [63:0] s0;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] s3;
        logic [63:0] s4;
    } ascon_state;

    localparam logic [7:0] ROUND_CONST [0:11] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // p^12 runs constants 0..11, p^8 runs the last eight (4..11)
    localparam logic [3:0] P12_START = 4'd0;
    localparam logic [3:0] P8_START  = 4'd4;
    localparam logic [3:0] LAST_ROUND = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } perm_fsm_e;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/pl.sv
// pl: Ascon linear diffusion layer, each word xored with two rotations of itself.
module pl
    import ascon_aead128_pkg::*;
(
    input  ascon_state state_i,
    output ascon_state state_o
);

    assign state_o.s0 = state_i.s0 ^ rotr(state_i.s0, 19) ^ rotr(state_i.s0, 28);
    assign state_o.s1 = state_i.s1 ^ rotr(state_i.s1, 61) ^ rotr(state_i.s1, 39);
    assign state_o.s2 = state_i.s2 ^ rotr(state_i.s2, 1)  ^ rotr(state_i.s2, 6);
    assign state_o.s3 = state_i.s3 ^ rotr(state_i.s3, 10) ^ rotr(state_i.s3, 17);
    assign state_o.s4 = state_i.s4 ^ rotr(state_i.s4, 7)  ^ rotr(state_i.s4, 41);

endmodule

// File: rtl/ps.sv
// ps: Ascon substitution layer, the 5-bit s-box applied bit-sliced across all 64 columns.
module ps
    import ascon_aead128_pkg::*;
(
    input  ascon_state state_i,
    output ascon_state state_o
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;

    assign a0 = state_i.s0 ^ state_i.s4;
    assign a1 = state_i.s1;
    assign a2 = state_i.s2 ^ state_i.s1;
    assign a3 = state_i.s3;
    assign a4 = state_i.s4 ^ state_i.s3;

    // chi-like nonlinear step on the pre-mixed words
    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign state_o.s0 = b0 ^ b4;
    assign state_o.s1 = b1 ^ b0;
    assign state_o.s2 = ~b2;
    assign state_o.s3 = b3 ^ b2;
    assign state_o.s4 = b4;

endmodule

// File: rtl/permutation_engine.sv
// permutation_engine: iterative Ascon p^12 / p^8, one pc->ps->pl round per clock,
// with a start/busy/done handshake toward the mode controller.
module permutation_engine
    import ascon_aead128_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rounds_sel,
    input  ascon_state state_in,
    output ascon_state state_out,
    output logic       busy,
    output logic       done
);

    perm_fsm_e  fsm_q, fsm_d;
    logic [3:0] round_q, round_d;
    ascon_state state_q, state_d;
    ascon_state pc_s, ps_s, pl_s;

    always_comb begin
        pc_s         = state_q;
        pc_s.s2[7:0] = state_q.s2[7:0] ^ ROUND_CONST[round_q];
    end

    ps u_ps (
        .state_i(pc_s),
        .state_o(ps_s)
    );

    pl u_pl (
        .state_i(ps_s),
        .state_o(pl_s)
    );

    // start is honoured in IDLE and DONE alike, which gives back-to-back throughput
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        if (fsm_q == RUN) begin
            state_d = pl_s;
            round_d = (round_q == LAST_ROUND) ? round_q : round_q + 4'd1;
            fsm_d   = (round_q == LAST_ROUND) ? DONE : RUN;
        end else if (start) begin
            state_d = state_in;
            round_d = rounds_sel ? P12_START : P8_START;
            fsm_d   = RUN;
        end else begin
            fsm_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    assign state_out = state_q;
    assign busy      = (fsm_q == RUN);
    assign done      = (fsm_q == DONE);

endmodule

// File: tb/tb_permutation_engine.sv
// tb_permutation_engine: directed checks of permutation_engine against a table-driven Ascon model.
module tb_permutation_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         rounds_sel = 1'b0;
    logic [319:0] state_in = '0;
    logic [319:0] state_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    localparam logic [319:0] ZERO_ST = 320'h0;
    localparam logic [319:0] INIT_ST = {64'h00001000808c0001, 256'h0};
    localparam logic [319:0] VEC_A = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                      64'h0f1e2d3c4b5a6978, 64'h8796a5b4c3d2e1f0,
                                      64'hdeadbeefcafef00d};
    localparam logic [319:0] VEC_B = {64'hffffffffffffffff, 64'h0000000000000001,
                                      64'h8000000000000000, 64'h5555555555555555,
                                      64'haaaaaaaaaaaaaaaa};

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    permutation_engine dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rounds_sel(rounds_sel),
        .state_in(state_in),
        .state_out(state_out),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Reference: column-wise s-box table, constants built as {15-i, i}
    function automatic logic [319:0] model_perm(input logic [319:0] s_in, input int first);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        for (int k = 0; k < 5; k++) x[k] = s_in[319 - 64 * k -: 64];
        for (int r = first; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ {4'(15 - r), 4'(r)};
            for (int j = 0; j < 64; j++) begin
                v = SBOX[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
                for (int k = 0; k < 5; k++) y[k][j] = v[4 - k];
            end
            x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
            x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
            x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
            x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
            x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    // Counts edges after the accept edge until done is seen; -1 if it never comes
    task automatic wait_done(output int n, output bit busy_ok);
        n = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic launch(input logic [319:0] s, input logic sel);
        start = 1'b1;
        rounds_sel = sel;
        state_in = s;
        @(posedge clk); #1;
        start = 1'b0;
        state_in = ~s;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (state_out !== 320'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: state_out=%h busy=%b done=%b, required 0/0/0", state_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_p12_zero();
        int n;
        bit bok;
        logic [319:0] exp_s;
        exp_s = model_perm(ZERO_ST, 0);
        launch(ZERO_ST, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL p12_busy_first: busy=%b, required 1", busy);
        end
        wait_done(n, bok);
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL p12_latency: edges=%0d, required 12", n);
        end
        checks++;
        if (state_out !== exp_s) begin
            errors++;
            $display("FAIL p12_zero_result: got %h, required %h", state_out, exp_s);
        end
        checks++;
        if (!bok || busy !== 1'b0) begin
            errors++;
            $display("FAIL p12_busy_window: busy_ok=%b busy_in_done=%b, required 1/0", bok, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL p12_done_pulse: done=%b busy=%b after DONE, required 0/0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (state_out !== exp_s) begin
            errors++;
            $display("FAIL idle_hold: got %h, required %h", state_out, exp_s);
        end
    endtask

    task automatic test_p8_init();
        int n;
        bit bok;
        logic [319:0] exp_s;
        exp_s = model_perm(INIT_ST, 4);
        launch(INIT_ST, 1'b0);
        wait_done(n, bok);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL p8_latency: edges=%0d, required 8", n);
        end
        checks++;
        if (state_out !== exp_s) begin
            errors++;
            $display("FAIL p8_init_result: got %h, required %h", state_out, exp_s);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL p8_busy_window: busy dropped during RUN, required high");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_held();
        int n;
        int extra;
        logic [319:0] exp_s;
        exp_s = model_perm(VEC_A, 0);
        n = -1;
        extra = 0;
        start = 1'b1;
        rounds_sel = 1'b1;
        state_in = VEC_A;
        @(posedge clk); #1;
        for (int i = 1; i <= 40; i++) begin
            state_in = {state_in[318:0], state_in[319]} ^ 320'(i);
            rounds_sel = ~rounds_sel;
            @(posedge clk); #1;
            if (done) begin
                n = i;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL held_latency: edges=%0d, required 12", n);
        end
        checks++;
        if (state_out !== exp_s) begin
            errors++;
            $display("FAIL held_result: got %h, required %h", state_out, exp_s);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL held_extra_pulse: %0d busy/done cycles after, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit bok;
        logic [319:0] exp_a;
        logic [319:0] exp_b;
        exp_a = model_perm(VEC_A, 0);
        exp_b = model_perm(VEC_B, 0);
        launch(VEC_A, 1'b1);
        wait_done(n, bok);
        checks++;
        if (n !== 12 || state_out !== exp_a) begin
            errors++;
            $display("FAIL b2b_first: edges=%0d got %h, required 12 / %h", n, state_out, exp_a);
        end
        start = 1'b1;
        rounds_sel = 1'b1;
        state_in = VEC_B;
        @(posedge clk); #1;
        start = 1'b0;
        state_in = '0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap: busy=%b done=%b, required 1/0", busy, done);
        end
        wait_done(n, bok);
        // one edge for the accept plus twelve more: 13 edges from the first done
        checks++;
        if (n + 1 !== 13) begin
            errors++;
            $display("FAIL b2b_spacing: edges=%0d, required 13", n + 1);
        end
        checks++;
        if (state_out !== exp_b) begin
            errors++;
            $display("FAIL b2b_second: got %h, required %h", state_out, exp_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit bok;
        int pulses;
        logic [319:0] exp_s;
        exp_s = model_perm(VEC_B, 0);
        pulses = 0;
        launch(VEC_A, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_out !== 320'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state_out=%h busy=%b done=%b, required 0/0/0", state_out, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done cycles, required 0", pulses);
        end
        launch(VEC_B, 1'b1);
        wait_done(n, bok);
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL post_reset_latency: edges=%0d, required 12", n);
        end
        checks++;
        if (state_out !== exp_s) begin
            errors++;
            $display("FAIL post_reset_result: got %h, required %h", state_out, exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_p12_zero();
        test_p8_init();
        test_start_held();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
